// File: rtl/life_ram_pkg.sv
// life_ram_pkg: shared address width and read-owner tag type for the RAM port arbiter.
// Revision: 1.0
`default_nettype none

package life_ram_pkg;

    localparam int ADDR_W = 24;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_LD   = 2'd2,
        OWN_ENG  = 2'd3
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/ram_rd_tag_pipe.sv
// ram_rd_tag_pipe: DEPTH-stage shift register of read-owner tags, aligned to RAM read latency.
// Revision: 1.0
`default_nettype none

module ram_rd_tag_pipe
    import life_ram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_t i_tag,
    output owner_t o_tag
);

    owner_t r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= OWN_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: three-requester single-port RAM arbiter (display > loader > engine)
// with in-order read return. Optional macro ARB_STARVE_GUARD_EN adds engine anti-starvation.
// Revision: 1.0
`default_nettype none

module ram_port_arbiter
    import life_ram_pkg::*;
#(
    parameter int BLOCK_LEN    = 32,
    parameter int RAM_RD_LAT   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk_ram,
    input  logic                  reset,

    input  logic                  disp_req,
    input  logic [ADDR_W-1:0]     disp_addr,
    output logic                  disp_gnt,
    output logic                  disp_rvalid,

    input  logic                  ld_req,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [BLOCK_LEN-1:0]  ld_wdata,
    output logic                  ld_gnt,

    input  logic                  eng_req,
    input  logic                  eng_we,
    input  logic [ADDR_W-1:0]     eng_addr,
    input  logic [BLOCK_LEN-1:0]  eng_wdata,
    output logic                  eng_gnt,
    output logic                  eng_rvalid,

    output logic [BLOCK_LEN-1:0]  rdata,

    output logic [ADDR_W-1:0]     ram_address,
    output logic [BLOCK_LEN-1:0]  ram_write_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [BLOCK_LEN-1:0]  ram_read_data
);

    logic                 w_eng_first;
    logic                 w_disp_gnt;
    logic                 w_ld_gnt;
    logic                 w_eng_gnt;
    logic                 w_rd_issue;
    logic                 w_wr_issue;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [BLOCK_LEN-1:0] w_sel_wdata;
    owner_t               w_issue_owner;
    owner_t               w_ret_owner;
    logic                 w_disp_ret;
    logic                 w_eng_ret;

    logic [ADDR_W-1:0]    r_ram_address;
    logic [BLOCK_LEN-1:0] r_ram_wdata;
    logic                 r_ram_rden;
    logic                 r_ram_wren;
    owner_t               r_rd_owner;
    logic [BLOCK_LEN-1:0] r_rdata;

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] r_starve_cnt;

    // Saturates rather than wrapping so a long-starved engine keeps its boost.
    always_ff @(posedge clk_ram) begin
        if (reset) begin
            r_starve_cnt <= 8'd0;
        end else if (w_eng_gnt) begin
            r_starve_cnt <= 8'd0;
        end else if (eng_req && (r_starve_cnt != 8'hFF)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    assign w_eng_first = (int'(r_starve_cnt) >= STARVE_LIMIT);
`else
    assign w_eng_first = 1'b0;
`endif

    always_comb begin
        w_disp_gnt    = 1'b0;
        w_ld_gnt      = 1'b0;
        w_eng_gnt     = 1'b0;
        w_rd_issue    = 1'b0;
        w_wr_issue    = 1'b0;
        w_sel_addr    = r_ram_address;
        w_sel_wdata   = r_ram_wdata;
        w_issue_owner = OWN_NONE;
        if (!reset) begin
            if (disp_req) begin
                w_disp_gnt    = 1'b1;
                w_rd_issue    = 1'b1;
                w_sel_addr    = disp_addr;
                w_issue_owner = OWN_DISP;
            end else if (eng_req && (w_eng_first || !ld_req)) begin
                w_eng_gnt  = 1'b1;
                w_sel_addr = eng_addr;
                if (eng_we) begin
                    w_wr_issue  = 1'b1;
                    w_sel_wdata = eng_wdata;
                end else begin
                    w_rd_issue    = 1'b1;
                    w_issue_owner = OWN_ENG;
                end
            end else if (ld_req) begin
                w_ld_gnt    = 1'b1;
                w_wr_issue  = 1'b1;
                w_sel_addr  = ld_addr;
                w_sel_wdata = ld_wdata;
            end
        end
    end

    always_ff @(posedge clk_ram) begin
        if (reset) begin
            r_ram_address <= '0;
            r_ram_wdata   <= '0;
            r_ram_rden    <= 1'b0;
            r_ram_wren    <= 1'b0;
            r_rd_owner    <= OWN_NONE;
        end else begin
            r_ram_rden    <= w_rd_issue;
            r_ram_wren    <= w_wr_issue;
            r_rd_owner    <= w_issue_owner;
            r_ram_address <= w_sel_addr;
            r_ram_wdata   <= w_sel_wdata;
        end
    end

    // Tag enters with the registered rden, so it emerges exactly when read data does.
    ram_rd_tag_pipe #(
        .DEPTH (RAM_RD_LAT)
    ) u_tag_pipe (
        .clk   (clk_ram),
        .rst   (reset),
        .i_tag (r_rd_owner),
        .o_tag (w_ret_owner)
    );

    assign w_disp_ret = !reset && (w_ret_owner == OWN_DISP);
    assign w_eng_ret  = !reset && (w_ret_owner == OWN_ENG);

    always_ff @(posedge clk_ram) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_disp_ret || w_eng_ret) begin
            r_rdata <= ram_read_data;
        end
    end

    assign disp_gnt       = w_disp_gnt;
    assign ld_gnt         = w_ld_gnt;
    assign eng_gnt        = w_eng_gnt;
    assign disp_rvalid    = w_disp_ret;
    assign eng_rvalid     = w_eng_ret;
    assign rdata          = reset ? '0 : ((w_disp_ret || w_eng_ret) ? ram_read_data : r_rdata);
    assign ram_address    = reset ? '0 : r_ram_address;
    assign ram_write_data = reset ? '0 : r_ram_wdata;
    assign ram_rden       = !reset && r_ram_rden;
    assign ram_wren       = !reset && r_ram_wren;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed checks of ram_port_arbiter against a cycle model.
// Revision: 1.0
`default_nettype none

module tb_ram_port_arbiter;

    localparam int LAT   = 2;
    localparam int LIMIT = 8;
    localparam int W     = 32;

    logic          clk_ram = 1'b0;
    logic          reset   = 1'b1;
    logic          disp_req = 1'b0;
    logic [23:0]   disp_addr = '0;
    logic          ld_req = 1'b0;
    logic [23:0]   ld_addr = '0;
    logic [W-1:0]  ld_wdata = '0;
    logic          eng_req = 1'b0;
    logic          eng_we = 1'b0;
    logic [23:0]   eng_addr = '0;
    logic [W-1:0]  eng_wdata = '0;
    logic [W-1:0]  ram_read_data = '0;

    logic          disp_gnt, disp_rvalid, ld_gnt, eng_gnt, eng_rvalid;
    logic [W-1:0]  rdata, ram_write_data;
    logic [23:0]   ram_address;
    logic          ram_rden, ram_wren;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_ram = ~clk_ram;

    ram_port_arbiter #(
        .BLOCK_LEN    (W),
        .RAM_RD_LAT   (LAT),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk_ram        (clk_ram),
        .reset          (reset),
        .disp_req       (disp_req),
        .disp_addr      (disp_addr),
        .disp_gnt       (disp_gnt),
        .disp_rvalid    (disp_rvalid),
        .ld_req         (ld_req),
        .ld_addr        (ld_addr),
        .ld_wdata       (ld_wdata),
        .ld_gnt         (ld_gnt),
        .eng_req        (eng_req),
        .eng_we         (eng_we),
        .eng_addr       (eng_addr),
        .eng_wdata      (eng_wdata),
        .eng_gnt        (eng_gnt),
        .eng_rvalid     (eng_rvalid),
        .rdata          (rdata),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_rden       (ram_rden),
        .ram_wren       (ram_wren),
        .ram_read_data  (ram_read_data)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model + compare (mid-cycle, on negedge) ----------------
    logic         g_d = 1'b0, g_l = 1'b0, g_e = 1'b0;
    logic [23:0]  m_addr = '0;
    logic [W-1:0] m_wdata = '0;
    logic         m_rden = 1'b0, m_wren = 1'b0;
    logic [W-1:0] m_hold = '0;
    int           m_cnt = 0;
    int           sched [8];
    int           t = 0;

    initial begin
        logic e_d, e_l, e_e, eng_first, ex_dv, ex_ev;
        logic [W-1:0] ex_rdata;
        int own;
        for (int i = 0; i < 8; i++) sched[i] = 0;
        forever begin
            @(negedge clk_ram);
            t++;
            e_d = 1'b0; e_l = 1'b0; e_e = 1'b0; eng_first = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            eng_first = (m_cnt >= LIMIT);
`endif
            if (!reset) begin
                if (disp_req) e_d = 1'b1;
                else if (ld_req && eng_req) begin
                    if (eng_first) e_e = 1'b1; else e_l = 1'b1;
                end
                else if (ld_req) e_l = 1'b1;
                else if (eng_req) e_e = 1'b1;
            end
            own = sched[t % 8];
            sched[t % 8] = 0;
            ex_dv = !reset && (own == 1);
            ex_ev = !reset && (own == 3);
            ex_rdata = reset ? '0 : ((ex_dv || ex_ev) ? ram_read_data : m_hold);

            chk("disp_gnt",   disp_gnt,   e_d);
            chk("ld_gnt",     ld_gnt,     e_l);
            chk("eng_gnt",    eng_gnt,    e_e);
            chk("disp_rvalid", disp_rvalid, ex_dv);
            chk("eng_rvalid", eng_rvalid, ex_ev);
            chk("rdata",      rdata,      ex_rdata);
            chk("ram_rden",   ram_rden,   reset ? 1'b0 : m_rden);
            chk("ram_wren",   ram_wren,   reset ? 1'b0 : m_wren);
            chk("ram_address", ram_address, reset ? 24'd0 : m_addr);
            chk("ram_write_data", ram_write_data, reset ? '0 : m_wdata);

            if (reset) begin
                m_addr = '0; m_wdata = '0; m_rden = 1'b0; m_wren = 1'b0;
                m_hold = '0; m_cnt = 0;
                for (int i = 0; i < 8; i++) sched[i] = 0;
            end else begin
                if (ex_dv || ex_ev) m_hold = ram_read_data;
                m_rden = 1'b0; m_wren = 1'b0;
                if (e_d) begin
                    m_addr = disp_addr; m_rden = 1'b1; sched[(t + 1 + LAT) % 8] = 1;
                end else if (e_l) begin
                    m_addr = ld_addr; m_wdata = ld_wdata; m_wren = 1'b1;
                end else if (e_e) begin
                    m_addr = eng_addr;
                    if (eng_we) begin
                        m_wdata = eng_wdata; m_wren = 1'b1;
                    end else begin
                        m_rden = 1'b1; sched[(t + 1 + LAT) % 8] = 3;
                    end
                end
                if (e_e) m_cnt = 0;
                else if (eng_req && m_cnt < 255) m_cnt++;
            end
            g_d = e_d; g_l = e_l; g_e = e_e;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_ram);
        #1;
    endtask

    task automatic look();
        #5;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        disp_req = 1'b0; ld_req = 1'b0; eng_req = 1'b0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        logic star;
        int pd;
        star = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        star = 1'b1;
`endif
        // Single display read at 0x10
        do_reset(3);
        disp_req = 1'b1; disp_addr = 24'h000010;
        look(); chk("r030_gnt", disp_gnt, 1);
        step(); disp_req = 1'b0;
        look(); chk("r030_rden", ram_rden, 1); chk("r030_addr", ram_address, 32'h10);
        step(); look(); chk("r030_early", disp_rvalid, 0);
        step(); ram_read_data = 32'hCAFE0010;
        look(); chk("r030_rvalid", disp_rvalid, 1); chk("r030_rdata", rdata, 32'hCAFE0010);
        step(); ram_read_data = 32'h0BADF00D;
        look(); chk("r030_once", disp_rvalid, 0); chk("r030_hold", rdata, 32'hCAFE0010);

        // All three request together
        step(); disp_req = 1'b1; ld_req = 1'b1; ld_addr = 24'h5; ld_wdata = 32'h55;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 24'h7;
        look(); chk("r031_disp", disp_gnt, 1); chk("r031_ld0", ld_gnt, 0); chk("r031_eng0", eng_gnt, 0);
        step(); disp_req = 1'b0;
        look(); chk("r031_ld", ld_gnt, 1); chk("r031_eng1", eng_gnt, 0);
        step(); ld_req = 1'b0;
        look(); chk("r031_eng", eng_gnt, 1);
        step(); eng_req = 1'b0;
        repeat (6) step();

        // Loader write
        do_reset(2);
        ld_req = 1'b1; ld_addr = 24'h000123; ld_wdata = 32'hDEADBEEF;
        look(); chk("r033_gnt", ld_gnt, 1);
        step(); ld_req = 1'b0;
        look(); chk("r033_wren", ram_wren, 1); chk("r033_addr", ram_address, 32'h123);
        chk("r033_data", ram_write_data, 32'hDEADBEEF); chk("r033_rden", ram_rden, 0);
        step(); look(); chk("r033_once", ram_wren, 0);
        for (int k = 0; k < 4; k++) begin
            step(); look(); chk("r033_norv", {disp_rvalid, eng_rvalid}, 0);
        end

        // Engine read then display read: in-order return
        do_reset(2);
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 24'h200;
        look(); chk("r032_egnt", eng_gnt, 1);
        step(); eng_req = 1'b0; disp_req = 1'b1; disp_addr = 24'h300;
        look(); chk("r032_dgnt", disp_gnt, 1);
        step(); disp_req = 1'b0;
        look(); chk("r032_none", {disp_rvalid, eng_rvalid}, 0);
        step(); ram_read_data = 32'h11111111;
        look(); chk("r032_erv", {disp_rvalid, eng_rvalid}, 2'b01); chk("r032_ed", rdata, 32'h11111111);
        step(); ram_read_data = 32'h22222222;
        look(); chk("r032_drv", {disp_rvalid, eng_rvalid}, 2'b10); chk("r032_dd", rdata, 32'h22222222);

        // Loader and engine both continuous
        do_reset(2);
        ld_req = 1'b1; ld_addr = 24'h40; eng_req = 1'b1; eng_we = 1'b1; eng_addr = 24'h80;
        for (int k = 1; k <= 12; k++) begin
            look();
            chk("r034_eng", eng_gnt, (star && k == 9) ? 1 : 0);
            chk("r034_ld", ld_gnt, (star && k == 9) ? 0 : 1);
            step();
            if (g_e) eng_req = 1'b0;
            ld_wdata = $urandom; ld_addr = ld_addr + 24'd1;
        end

        // Reset right after an engine read grant
        do_reset(2);
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 24'h9;
        look(); chk("r035_gnt", eng_gnt, 1);
        step(); eng_req = 1'b0; reset = 1'b1; disp_req = 1'b1; disp_addr = 24'h77;
        for (int k = 0; k < 2; k++) begin
            look();
            chk("r035_cmd", {ram_rden, ram_wren, disp_gnt, disp_rvalid, eng_rvalid}, 0);
            chk("r035_addr", ram_address, 0); chk("r035_rdata", rdata, 0);
            step();
        end
        reset = 1'b0; disp_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            look(); chk("r035_norv", eng_rvalid, 0);
            step();
        end

        // Randomized traffic
        do_reset(2);
        for (int c = 0; c < 4000; c++) begin
            step();
            if (g_d) disp_req = 1'b0;
            if (g_l) ld_req = 1'b0;
            if (g_e) eng_req = 1'b0;
            pd = ((c / 500) % 2 == 1) ? 5 : 35;
            if (!disp_req && $urandom_range(0, 99) < pd) begin
                disp_req = 1'b1; disp_addr = 24'($urandom);
            end
            if (!ld_req && $urandom_range(0, 99) < 75) begin
                ld_req = 1'b1; ld_addr = 24'($urandom); ld_wdata = $urandom;
            end
            if (!eng_req && $urandom_range(0, 99) < 60) begin
                eng_req = 1'b1; eng_we = 1'($urandom); eng_addr = 24'($urandom); eng_wdata = $urandom;
            end
            ram_read_data = $urandom;
            reset = ($urandom_range(0, 249) == 0);
        end
        reset = 1'b0;
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter BLOCK_LEN, default 32: RAM data word width in bits.
REQ-002 Parameter RAM_RD_LAT, default 2: cycles from ram_rden to a valid ram_read_data; legal range 1..4.
REQ-003 Parameter STARVE_LIMIT, default 8: engine wait-cycle threshold for the anti-starvation feature.
REQ-004 clk_ram  in  1: the only clock; all logic is on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 disp_req/disp_addr  in  1/24: VGA display read request and its word address.
REQ-007 disp_gnt/disp_rvalid  out  1/1: display grant; display read data is valid on rdata.
REQ-008 ld_req/ld_addr/ld_wdata  in  1/24/BLOCK_LEN: SD-card loader write request, address and data.
REQ-009 ld_gnt  out  1: loader grant.
REQ-010 eng_req/eng_we/eng_addr/eng_wdata  in  1/1/24/BLOCK_LEN: life-engine request; eng_we=1 is a write, eng_we=0 is a read.
REQ-011 eng_gnt/eng_rvalid  out  1/1: engine grant; engine read data is valid on rdata.
REQ-012 rdata  out  BLOCK_LEN: shared read-return data.
REQ-013 ram_address/ram_write_data/ram_rden/ram_wren  out  24/BLOCK_LEN/1/1: single-port RAM command.
REQ-014 ram_read_data  in  BLOCK_LEN: RAM read data.

Function
REQ-015 Grants are combinational from the current-cycle requests; at most one of disp_gnt, ld_gnt and eng_gnt is high in any cycle.
REQ-016 Priority order: display first, then loader, then engine (changed only by the REQ-026 feature).
REQ-017 A requester holds req, addr and data stable until it sees its gnt; each gnt cycle transfers exactly one word.
REQ-018 A request granted in cycle N drives ram_address, ram_write_data and ram_rden or ram_wren (exactly one) from registers in cycle N+1.
REQ-019 In any cycle with no grant, ram_rden=0 and ram_wren=0; ram_address and ram_write_data hold their last values.
REQ-020 For a read granted in cycle N, the matching requester's rvalid pulses for one cycle in cycle N+1+RAM_RD_LAT, and rdata equals ram_read_data in that cycle.
REQ-021 An owner-tag pipeline of depth RAM_RD_LAT tracks read ownership; back-to-back reads from different owners return in issue order, one per cycle.
REQ-022 Writes never produce an rvalid pulse.
REQ-023 Idle values: rdata holds its last value; no rvalid pulses.

Reset
REQ-024 While reset is high, every output is 0: grants, rvalids, ram_rden, ram_wren, ram_address, ram_write_data, rdata.
REQ-025 Reset clears the owner-tag pipeline and the starvation counter, so reads in flight at reset never produce rvalid afterwards.

Configuration
REQ-026 With ARB_STARVE_GUARD_EN defined: an 8-bit counter increments each cycle that eng_req=1 and eng_gnt=0.
REQ-026a The counter clears whenever eng_gnt=1.
REQ-026b When the counter is at or above STARVE_LIMIT, the engine wins over the loader; the display still wins over both.
REQ-027 Without ARB_STARVE_GUARD_EN: the counter logic is absent, and loader-over-engine priority is strict.

Structure
REQ-028 Package life_ram_pkg holds ADDR_W=24 and the owner enum owner_t {OWN_NONE, OWN_DISP, OWN_LD, OWN_ENG}.
REQ-029 One sub-module, ram_rd_tag_pipe (a parameterised-depth shift register of owner_t), is instantiated once.

Verification
REQ-030 Only disp_req, addr 0x000010, RAM_RD_LAT=2, granted in cycle 5 -> ram_rden in cycle 6; disp_rvalid and rdata=RAM word in cycle 8.
REQ-031 disp_req, ld_req and eng_req all high in the same cycle -> disp_gnt only; next cycle with disp_req low -> ld_gnt only.
REQ-032 Engine read granted in cycle N, display read granted in cycle N+1 -> eng_rvalid in cycle N+3, disp_rvalid in cycle N+4, each with its own data.
REQ-033 Loader writes 0xDEADBEEF to 0x000123 -> ram_wren=1 with that address and data for exactly one cycle; no rvalid.
REQ-034 Continuous ld_req and eng_req with the macro defined, STARVE_LIMIT=8 -> eng_gnt in the 9th cycle; without the macro, eng_gnt never occurs.
REQ-035 Reset asserted one cycle after an engine read grant -> all outputs 0 and no eng_rvalid for 10 cycles after reset is released.
